// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared widths, reset PC and encodings for the fetch sequencer
package pc_seq_pkg;

    localparam int unsigned PC_W = 9;
    localparam logic [PC_W-1:0] RESET_PC = {PC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_INC   = 2'd1,
        SEL_REDIR = 2'd2,
        SEL_PEND  = 2'd3
    } npc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC selection between hold, increment, redirect and stored redirect
module pc_next_mux
    import pc_seq_pkg::*;
(
    input  npc_sel_t        sel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] redir_tgt,
    input  logic [PC_W-1:0] pend_tgt,
    output logic [PC_W-1:0] npc
);

    // pc+1 wraps naturally at the PC width (1FF -> 000)
    always_comb begin
        npc = pc;
        case (sel)
            SEL_HOLD:  npc = pc;
            SEL_INC:   npc = pc + PC_W'(1);
            SEL_REDIR: npc = redir_tgt;
            SEL_PEND:  npc = pend_tgt;
            default:   npc = pc;
        endcase
    end

endmodule

// File: rtl/pc_seq.sv
// rtl/pc_seq.sv - instruction-fetch handshake and next-PC sequencing
module pc_seq
    import pc_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] npc,
    output logic            fetch_req,
    input  logic            fetch_ack,
    output logic            fetch_valid,
    input  logic            stall,
    input  logic            jmp,
    input  logic [PC_W-1:0] jmp_target,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            halt,
    output logic            halted
);

    seq_state_t      state_q, state_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
    npc_sel_t        sel;
    logic            redir;
    logic [PC_W-1:0] redir_tgt;
    logic [PC_W-1:0] mux_npc;

    assign redir     = jmp | br_taken;
    assign redir_tgt = jmp ? jmp_target : br_target;
    assign fetch_req = (state_q == ST_FETCH);
    assign halted    = (state_q == ST_HALT);

    // The PC register loads on the falling edge, so this state does too
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_BOOT;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    // Next state, redirect capture and next-PC choice; a redirect seen while
    // a fetch is outstanding is stored and the oldest one wins at ack time
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_tgt_d  = pend_tgt_q;
        sel         = SEL_HOLD;
        fetch_valid = 1'b0;
        case (state_q)
            ST_BOOT: begin
                sel     = SEL_INC;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!fetch_ack) begin
                    if (redir && !pend_q) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = redir_tgt;
                    end
                end else if (pend_q) begin
                    sel    = SEL_PEND;
                    pend_d = 1'b0;
                end else if (redir) begin
                    sel = SEL_REDIR;
                end else if (halt) begin
                    state_d = ST_HALT;
                end else if (stall) begin
                    state_d = ST_STALL;
                end else begin
                    sel         = SEL_INC;
                    fetch_valid = 1'b1;
                end
            end
            ST_STALL: begin
                if (redir) begin
                    sel     = SEL_REDIR;
                    state_d = ST_FETCH;
                end else if (halt) begin
                    state_d = ST_HALT;
                end else if (!stall) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    pc_next_mux u_pc_next_mux (
        .sel       (sel),
        .pc        (pc),
        .redir_tgt (redir_tgt),
        .pend_tgt  (pend_tgt_q),
        .npc       (mux_npc)
    );

    // While reset is held the PC register must be fed its reset value
    assign npc = rst ? mux_npc : RESET_PC;

endmodule

// File: tb/tb_pc_seq.sv
// tb/tb_pc_seq.sv - table-driven bench for the fetch sequencer
module tb_pc_seq;

    logic       clk;
    logic       rst;
    logic [8:0] pc;
    logic [8:0] npc;
    logic       fetch_req;
    logic       fetch_ack;
    logic       fetch_valid;
    logic       stall;
    logic       jmp;
    logic [8:0] jmp_target;
    logic       br_taken;
    logic [8:0] br_target;
    logic       halt;
    logic       halted;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic       ack;
        logic       stall;
        logic       jmp;
        logic [8:0] jt;
        logic       br;
        logic [8:0] bt;
        logic       halt;
        logic [8:0] e_npc;
        logic       e_req;
        logic       e_valid;
        logic       e_halted;
    } vec_t;

    vec_t vecs[$];

    pc_seq dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .npc         (npc),
        .fetch_req   (fetch_req),
        .fetch_ack   (fetch_ack),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .jmp         (jmp),
        .jmp_target  (jmp_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .halt        (halt),
        .halted      (halted)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Stand-in for the PC register: loads npc on every falling edge
    always @(negedge clk) pc <= npc;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ack, input logic st, input logic j, input logic [8:0] jt,
                       input logic b, input logic [8:0] bt, input logic h,
                       input logic [8:0] en, input logic er, input logic ev, input logic eh);
        vec_t v;
        v.ack = ack; v.stall = st; v.jmp = j; v.jt = jt; v.br = b; v.bt = bt; v.halt = h;
        v.e_npc = en; v.e_req = er; v.e_valid = ev; v.e_halted = eh;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        fetch_ack = 0; stall = 0; jmp = 0; jmp_target = '0;
        br_taken = 0; br_target = '0; halt = 0;
    endtask

    task automatic check_outs(input string tag, input logic [8:0] en, input logic er,
                              input logic ev, input logic eh);
        check({tag, " npc"}, int'(npc), int'(en));
        check({tag, " fetch_req"}, int'(fetch_req), int'(er));
        check({tag, " fetch_valid"}, int'(fetch_valid), int'(ev));
        check({tag, " halted"}, int'(halted), int'(eh));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pc = 9'h0AB;
        drive_idle();
        rst = 1'b0;

        //   ack st jmp jt     br bt     h   npc    req v  hlt
        add(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 0, 0, 0); // BOOT from 1FF
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h001, 1, 1, 0); // fetch 000
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h002, 1, 1, 0); // fetch 001
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h003, 1, 1, 0); // fetch 002
        add(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h003, 1, 0, 0); // slow ack wait 1
        add(0, 1, 0, 9'h000, 0, 9'h000, 0, 9'h003, 1, 0, 0); // wait 2, stall ignored
        add(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h003, 1, 0, 0); // wait 3
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h004, 1, 1, 0); // ack
        add(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h004, 1, 0, 0); // valid only one cycle
        add(1, 0, 1, 9'h010, 0, 9'h000, 0, 9'h010, 1, 0, 0); // jump on ack
        add(0, 0, 0, 9'h000, 1, 9'h040, 0, 9'h010, 1, 0, 0); // branch pended
        add(0, 0, 1, 9'h080, 0, 9'h000, 0, 9'h010, 1, 0, 0); // younger jump ignored
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h040, 1, 0, 0); // pended target used
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h041, 1, 1, 0); // pend cleared
        add(1, 0, 1, 9'h020, 1, 9'h0AA, 0, 9'h020, 1, 0, 0); // jmp beats branch
        add(1, 1, 0, 9'h000, 0, 9'h000, 0, 9'h020, 1, 0, 0); // ack with stall
        add(0, 1, 0, 9'h000, 0, 9'h000, 0, 9'h020, 0, 0, 0); // in STALL
        add(0, 1, 1, 9'h100, 0, 9'h000, 0, 9'h100, 0, 0, 0); // redirect beats stall
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h101, 1, 1, 0); // fetch 100
        add(1, 1, 0, 9'h000, 0, 9'h000, 0, 9'h101, 1, 0, 0); // stall again
        add(0, 0, 0, 9'h000, 0, 9'h000, 0, 9'h101, 0, 0, 0); // stall released
        add(1, 0, 1, 9'h1FF, 0, 9'h000, 0, 9'h1FF, 1, 0, 0); // refetch 101, jump to 1FF
        add(1, 0, 0, 9'h000, 0, 9'h000, 0, 9'h000, 1, 1, 0); // wrap 1FF -> 000
        add(0, 0, 0, 9'h000, 0, 9'h000, 1, 9'h000, 1, 0, 0); // halt ignored until ack
        add(0, 0, 0, 9'h000, 0, 9'h000, 1, 9'h000, 1, 0, 0);
        add(1, 0, 0, 9'h000, 0, 9'h000, 1, 9'h000, 1, 0, 0); // ack with halt
        add(1, 0, 1, 9'h0AA, 0, 9'h000, 0, 9'h000, 0, 0, 1); // HALT ignores jmp
        add(0, 1, 0, 9'h000, 1, 9'h033, 1, 9'h000, 0, 0, 1); // HALT ignores all

        // Reset state with the PC register loaded from npc
        @(negedge clk); #1;
        check_outs("reset", 9'h1FF, 0, 0, 0);
        check("reset pc", int'(pc), 'h1FF);
        rst = 1'b1;

        foreach (vecs[i]) begin
            fetch_ack = vecs[i].ack; stall = vecs[i].stall;
            jmp = vecs[i].jmp; jmp_target = vecs[i].jt;
            br_taken = vecs[i].br; br_target = vecs[i].bt; halt = vecs[i].halt;
            @(posedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_npc, vecs[i].e_req,
                       vecs[i].e_valid, vecs[i].e_halted);
            @(negedge clk); #1;
        end

        // Leave HALT via reset, then reset in the middle of a pended fetch
        drive_idle();
        rst = 1'b0;
        #1;
        check_outs("halt rst", 9'h1FF, 0, 0, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        check_outs("boot2", 9'h000, 0, 0, 0);
        @(negedge clk); #1;
        br_taken = 1; br_target = 9'h033;
        @(posedge clk);
        check_outs("pend2", 9'h000, 1, 0, 0);
        @(negedge clk); #1;
        drive_idle();
        #2;
        rst = 1'b0;
        #1;
        check_outs("midrst", 9'h1FF, 0, 0, 0);
        @(negedge clk); #1;
        check("midrst pc", int'(pc), 'h1FF);
        rst = 1'b1;
        @(posedge clk);
        check_outs("boot3", 9'h000, 0, 0, 0);
        @(negedge clk); #1;
        fetch_ack = 1;
        @(posedge clk);
        check_outs("post rst fetch", 9'h001, 1, 1, 0);
        @(negedge clk); #1;
        drive_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Fetch sequencer for the 9-bit program counter register. Each cycle that register loads whatever this block drives on npc.
- Runs the instruction-fetch handshake with instruction memory and chooses the next PC: sequential, jump, branch or hold.
- Holds the PC during hazard stalls. Stores a redirect that arrives while a fetch is outstanding and discards wrong-path words.
- Sits between the execute-stage redirect logic and the PC register / IMEM port.

Parameters:
- PC_W, 9, PC and target width.
- RESET_PC, all ones (9'h1FF), the PC register's reset value. BOOT increments it so that it wraps to 0.

Ports:
- clk  in  1  clock. All state updates on the falling edge, matching the PC register.
- rst  in  1  reset, asynchronous, active-low.
- pc  in  PC_W  current PC, fed back from the PC register output.
- npc  out  PC_W  next PC, driven to the PC register input.
- fetch_req  out  1  IMEM request; address is pc.
- fetch_ack  in  1  IMEM completion for the current request.
- fetch_valid  out  1  acked word is on the correct path and may enter decode.
- stall  in  1  hazard stall from decode.
- jmp  in  1  unconditional redirect.
- jmp_target  in  PC_W  jump target.
- br_taken  in  1  taken-branch redirect.
- br_target  in  PC_W  branch target.
- halt  in  1  stop fetching.
- halted  out  1  block is in HALT.

Behaviour:
- States: BOOT, FETCH, STALL, HALT. Registers: state, pend (1 bit), pend_tgt (PC_W).
- Reset (rst=0, async, takes effect immediately, including mid-handshake):
  - state=BOOT, pend=0, pend_tgt=0.
  - fetch_req=0, fetch_valid=0, halted=0.
  - npc forced to RESET_PC while rst=0.
- Combinational outputs:
  - fetch_req = (state==FETCH).
  - halted = (state==HALT).
  - redir = jmp | br_taken.
  - redir_tgt = jmp ? jmp_target : br_target; jmp has priority over br_taken.
- BOOT (exactly one cycle after rst release):
  - npc = pc+1, wrapping modulo 2^PC_W (1FF -> 000).
  - Next state FETCH; first fetch address is 0.
- FETCH, fetch_ack=0:
  - npc = pc.
  - fetch_req stays high; it is never dropped mid-handshake, and stall/halt are ignored until ack.
  - If redir and pend=0: pend<=1, pend_tgt<=redir_tgt.
  - If redir and pend=1: new redirect ignored; the pending one is older and wins.
- FETCH, fetch_ack=1, in priority order:
  - pend=1: npc=pend_tgt, pend<=0, fetch_valid=0, stay FETCH.
  - redir: npc=redir_tgt, fetch_valid=0, stay FETCH.
  - halt: npc=pc, fetch_valid=0, next HALT.
  - stall: npc=pc, fetch_valid=0, next STALL; the same pc is refetched later.
  - otherwise: npc=pc+1 (wraps), fetch_valid=1, stay FETCH.
- STALL:
  - fetch_req=0, npc=pc.
  - redir: npc=redir_tgt, next FETCH (redirect beats stall).
  - else halt: next HALT.
  - else stall=0: next FETCH.
- HALT: fetch_req=0, npc=pc, all inputs ignored. Exit only via rst.
- fetch_valid is combinational and can only be 1 in FETCH with fetch_ack=1.
- Latency: ack to npc=pc+1 is the same cycle; the PC register updates on that falling edge, so back-to-back single-cycle acks fetch one word per cycle.
- Wrap-around: pc=1FF with a good ack gives npc=000; no flag is raised.

Decomposition:
- Shared package holds:
  - the state encoding constants (BOOT=2'd0, FETCH=2'd1, STALL=2'd2, HALT=2'd3);
  - PC_W and RESET_PC, shared with the PC register.
- Sub-module pc_next_mux: combinational selection of pc+1 / redirect / pend_tgt / hold. The FSM and pend registers stay in pc_seq.

Test Plan:
- Boot with IMEM acking every cycle:
  - release rst with pc=1FF -> BOOT npc=000;
  - then fetch_req=1 at pc 000,001,002 with fetch_valid=1 on each.
- Slow IMEM, ack after 3 cycles:
  - fetch_req held high, npc=pc for 3 cycles;
  - on ack, npc=pc+1 and fetch_valid=1 for exactly 1 cycle.
- Pended redirect at pc=010, ack delayed:
  - cycle 1: br_taken=1, br_target=040; cycle 2: jmp=1, jmp_target=080;
  - at ack, npc=040 (jump ignored), fetch_valid=0, pend cleared;
  - next fetch is at 040.
- Redirect and stall together:
  - ack with stall=1 at pc=020 -> STALL, npc=020, fetch_valid=0;
  - in STALL, jmp=1, jmp_target=100 with stall still 1 -> npc=100, FETCH.
- Wrap and halt:
  - good ack at pc=1FF -> npc=000;
  - halt=1 while ack pending -> remains FETCH until ack, then HALT;
  - halted=1, fetch_req=0, npc holds; further jmp ignored.
- Reset mid-fetch:
  - drop rst while fetch_req=1 with pend=1 -> fetch_req=0 immediately, npc=1FF, pend=0;
  - on release, BOOT -> fetch at 000.
